decision_tree_engine: RTL and testbench
=======================================

DECISION_TREE_ENGINE -- requirements
Module: decision_tree_engine

Interface
REQ-001 Parameter NUM_FEATURES, default 25, number of features per sample.
REQ-002 Parameter FEAT_W, default 8, width of one feature and one threshold, unsigned.
REQ-003 Parameter DEPTH, default 4, number of tree levels; NUM_NODES = 2^DEPTH-1.
REQ-004 Parameter CLASS_W, default 2, width of class label.
REQ-005 Derived widths: FIDX_W = clog2(NUM_FEATURES), NODE_W = clog2(NUM_NODES), LVL_W = clog2(DEPTH) (min 1).
REQ-006 Ports, one per line:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_we  in  1  node-table write strobe.
- cfg_addr  in  NODE_W  node index to write.
- cfg_fidx  in  FIDX_W  feature index compared at the node.
- cfg_thr  in  FEAT_W  node threshold.
- cfg_leaf  in  1  node is a leaf.
- cfg_class  in  CLASS_W  class returned if leaf.
- in_valid  in  1  sample present.
- in_ready  out  1  engine accepts a sample.
- in_features  in  NUM_FEATURES*FEAT_W  packed sample; feature i at bits [i*FEAT_W +: FEAT_W].
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_class  out  CLASS_W  class of the terminating node.
- out_node  out  NODE_W  index of the terminating node.
- out_level  out  LVL_W  level of the terminating node (root = 0).
- cfg_busy  out  1  high when state is not IDLE.

Function
REQ-007 FSM states: IDLE, WALK, DONE; in_ready = (state==IDLE); out_valid = (state==DONE); cfg_busy = (state!=IDLE).
REQ-008 IDLE: in_valid&in_ready at an edge latches in_features into an internal sample register, sets node=0 and level=0, enters WALK.
REQ-009 WALK, one level per cycle: a node is terminal if its leaf flag is set or level==DEPTH-1. If terminal, the edge latches out_class=node class, out_node=node and out_level=level, and enters DONE.
REQ-010 WALK, non-terminal node: if sample[fidx] < thr (strict, unsigned), node <= 2*node+1 (left); otherwise node <= 2*node+2 (right); level increments.
REQ-011 A cfg_fidx >= NUM_FEATURES reads as feature value 0.
REQ-012 Latency: for a leaf at level L, out_valid rises L+1 cycles after the accepting edge; the maximum is DEPTH cycles.
REQ-013 DONE: out_class, out_node and out_level are held stable until out_valid&out_ready, then the FSM returns to IDLE; the next sample can be accepted at the following edge (no same-cycle turnaround).
REQ-014 The sample register is unaffected by in_features changes after acceptance.
REQ-015 cfg_we is honored only in IDLE; writes in WALK/DONE are dropped silently; writes with cfg_addr >= NUM_NODES are dropped.
REQ-016 cfg_we and an accepted in_valid in the same IDLE cycle: both take effect; traversal uses the updated table from the first WALK cycle.

Reset
REQ-017 On rst: state=IDLE; node table all fields 0; sample register 0; node=0, level=0; out_class, out_node, out_level = 0. Resulting outputs: in_ready=1, out_valid=0, cfg_busy=0.
REQ-018 rst mid-traversal or in DONE aborts the walk; no result is emitted for the aborted sample.

Structure
REQ-019 Package decision_tree_pkg holds the state enum, the node record (fidx, thr, leaf, class), the clog2 function and default parameter constants.
REQ-020 Sub-module dt_node_table: NUM_NODES-entry register file, one synchronous write port, one asynchronous read port, reset-cleared.

Verification
REQ-021 Default parameters. Program node0 (f0, thr 10), node1 (f1, 20), node3 leaf class 2. Sample f0=5, f1=3 -> out_valid 3 cycles after acceptance; out_class=2, out_node=3, out_level=2.
REQ-022 All non-leaf nodes thr 0 (always right), leaf flags clear. Any sample -> out_node=14, out_level=3, out_valid 4 cycles after acceptance.
REQ-023 node0 leaf class 1. Sample accepted -> out_valid 1 cycle later, out_class=1, out_node=0; hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
REQ-024 During WALK: issue cfg_we to node0 and change in_features -> the result is unchanged; a subsequent readback traversal shows the write was dropped.
REQ-025 Assert rst in the WALK cycle of level 1 -> out_valid never rises, in_ready=1 after reset; the table is cleared (next sample goes right to node 14).

Source files
------------

// File: rtl/decision_tree_pkg.sv
// Shared types and constants for the decision-tree inference engine.
// The node record is sized for the widest supported configuration; narrower instances zero-extend.
package decision_tree_pkg;

  localparam int unsigned DefNumFeatures = 25;
  localparam int unsigned DefFeatW       = 8;
  localparam int unsigned DefDepth       = 4;
  localparam int unsigned DefClassW      = 2;

  localparam int unsigned MaxFidxW  = 16;
  localparam int unsigned MaxFeatW  = 32;
  localparam int unsigned MaxClassW = 8;

  typedef enum logic [1:0] {StIdle, StWalk, StDone} state_e;

  typedef struct packed {
    logic [MaxFidxW-1:0]  fidx;
    logic [MaxFeatW-1:0]  thr;
    logic                 leaf;
    logic [MaxClassW-1:0] node_class;
  } node_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/dt_node_table.sv
// Node table: reset-cleared register file with one synchronous write and one combinational read.
module dt_node_table
  import decision_tree_pkg::*;
#(
  parameter int unsigned NUM_NODES = 15,
  parameter int unsigned NODE_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [NODE_W-1:0] waddr,
  input  node_t             wdata,
  input  logic [NODE_W-1:0] raddr,
  output node_t             rdata
);

  node_t mem_q [NUM_NODES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_NODES; i++) mem_q[i] <= '0;
    end else if (we && (32'(waddr) < NUM_NODES)) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (32'(raddr) < NUM_NODES) rdata = mem_q[raddr];
  end

endmodule

// File: rtl/decision_tree_engine.sv
// Decision-tree inference engine: walks one tree level per cycle from the root to a leaf
// (or the deepest level) and holds the result until the consumer takes it.
module decision_tree_engine
  import decision_tree_pkg::*;
#(
  parameter int unsigned NUM_FEATURES = DefNumFeatures,
  parameter int unsigned FEAT_W       = DefFeatW,
  parameter int unsigned DEPTH        = DefDepth,
  parameter int unsigned CLASS_W      = DefClassW,
  localparam int unsigned NUM_NODES   = (1 << DEPTH) - 1,
  localparam int unsigned FIDX_W      = (clog2(NUM_FEATURES) < 1) ? 1 : clog2(NUM_FEATURES),
  localparam int unsigned NODE_W      = (clog2(NUM_NODES) < 1) ? 1 : clog2(NUM_NODES),
  localparam int unsigned LVL_W       = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_we,
  input  logic [NODE_W-1:0]              cfg_addr,
  input  logic [FIDX_W-1:0]              cfg_fidx,
  input  logic [FEAT_W-1:0]              cfg_thr,
  input  logic                           cfg_leaf,
  input  logic [CLASS_W-1:0]             cfg_class,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_FEATURES*FEAT_W-1:0] in_features,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CLASS_W-1:0]             out_class,
  output logic [NODE_W-1:0]              out_node,
  output logic [LVL_W-1:0]               out_level,
  output logic                           cfg_busy
);

  state_e                         state_q, state_d;
  logic [NUM_FEATURES*FEAT_W-1:0] sample_q, sample_d;
  logic [NODE_W-1:0]              node_q, node_d;
  logic [LVL_W-1:0]               level_q, level_d;
  logic [CLASS_W-1:0]             out_class_q, out_class_d;
  logic [NODE_W-1:0]              out_node_q, out_node_d;
  logic [LVL_W-1:0]               out_level_q, out_level_d;

  node_t             wr_node, rd_node;
  logic              table_we;
  logic [FEAT_W-1:0] feat_val;
  logic              go_left;
  logic              terminal;
  logic              unused_class_bits;

  // Table updates are only allowed while no sample is in flight.
  assign table_we = cfg_we && (state_q == StIdle);

  always_comb begin
    wr_node            = '0;
    wr_node.fidx       = MaxFidxW'(cfg_fidx);
    wr_node.thr        = MaxFeatW'(cfg_thr);
    wr_node.leaf       = cfg_leaf;
    wr_node.node_class = MaxClassW'(cfg_class);
  end

  dt_node_table #(
    .NUM_NODES (NUM_NODES),
    .NODE_W    (NODE_W)
  ) u_node_table (
    .clk   (clk),
    .rst   (rst),
    .we    (table_we),
    .waddr (cfg_addr),
    .wdata (wr_node),
    .raddr (node_q),
    .rdata (rd_node)
  );

  // Out-of-range feature indices match no entry and therefore read as zero.
  always_comb begin
    feat_val = '0;
    for (int unsigned i = 0; i < NUM_FEATURES; i++) begin
      if (rd_node.fidx == MaxFidxW'(i)) feat_val = sample_q[i*FEAT_W +: FEAT_W];
    end
  end

  assign go_left           = MaxFeatW'(feat_val) < rd_node.thr;
  assign terminal          = rd_node.leaf || (level_q == LVL_W'(DEPTH - 1));
  assign unused_class_bits = ^rd_node.node_class;

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    node_d      = node_q;
    level_d     = level_q;
    out_class_d = out_class_q;
    out_node_d  = out_node_q;
    out_level_d = out_level_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sample_d = in_features;
          node_d   = '0;
          level_d  = '0;
          state_d  = StWalk;
        end
      end
      StWalk: begin
        if (terminal) begin
          out_class_d = CLASS_W'(rd_node.node_class);
          out_node_d  = node_q;
          out_level_d = level_q;
          state_d     = StDone;
        end else begin
          node_d  = (node_q << 1) + (go_left ? NODE_W'(1) : NODE_W'(2));
          level_d = level_q + LVL_W'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sample_q    <= '0;
      node_q      <= '0;
      level_q     <= '0;
      out_class_q <= '0;
      out_node_q  <= '0;
      out_level_q <= '0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      node_q      <= node_d;
      level_q     <= level_d;
      out_class_q <= out_class_d;
      out_node_q  <= out_node_d;
      out_level_q <= out_level_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign cfg_busy  = (state_q != StIdle);
  assign out_class = out_class_q;
  assign out_node  = out_node_q;
  assign out_level = out_level_q;

endmodule

// File: tb/tb_decision_tree_engine.sv
// Directed bench for decision_tree_engine at default parameters; inputs change and outputs are
// sampled on the falling clock edge.
module tb_decision_tree_engine;

  localparam int NF  = 25;
  localparam int FW  = 8;
  localparam int CW  = 2;
  localparam int NW  = 4;
  localparam int FIW = 5;
  localparam int LW  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [NW-1:0]    cfg_addr;
  logic [FIW-1:0]   cfg_fidx;
  logic [FW-1:0]    cfg_thr;
  logic             cfg_leaf;
  logic [CW-1:0]    cfg_class;
  logic             in_valid;
  logic             in_ready;
  logic [NF*FW-1:0] in_features;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_class;
  logic [NW-1:0]    out_node;
  logic [LW-1:0]    out_level;
  logic             cfg_busy;

  int checks   = 0;
  int failures = 0;

  decision_tree_engine #(
    .NUM_FEATURES (NF),
    .FEAT_W       (FW),
    .DEPTH        (4),
    .CLASS_W      (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_fidx    (cfg_fidx),
    .cfg_thr     (cfg_thr),
    .cfg_leaf    (cfg_leaf),
    .cfg_class   (cfg_class),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_features (in_features),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_class   (out_class),
    .out_node    (out_node),
    .out_level   (out_level),
    .cfg_busy    (cfg_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [NF*FW-1:0] feats(input logic [7:0] f0, input logic [7:0] f1,
                                             input logic [7:0] f2);
    logic [NF*FW-1:0] v;
    v        = '0;
    v[7:0]   = f0;
    v[15:8]  = f1;
    v[23:16] = f2;
    return v;
  endfunction

  task automatic cfg(input int addr, input int fidx, input int thr, input int leaf, input int cls);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = NW'(addr);
    cfg_fidx  = FIW'(fidx);
    cfg_thr   = FW'(thr);
    cfg_leaf  = leaf[0];
    cfg_class = CW'(cls);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic clear_table();
    for (int a = 0; a < 15; a++) cfg(a, 0, 0, 0, 0);
  endtask

  task automatic program_basic();
    cfg(0, 0, 10, 0, 0);
    cfg(1, 1, 20, 0, 0);
    cfg(3, 0, 0, 1, 2);
  endtask

  // Ends on the falling edge just after the accepting edge.
  task automatic start(input logic [NF*FW-1:0] f);
    @(negedge clk);
    check("in_ready before accept", 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    in_features = f;
    @(negedge clk);
    in_valid = 1'b0;
    check("busy after accept", 32'(cfg_busy), 32'd1);
  endtask

  task automatic await(input string tag, input int lat0, input int exp_lat, input int exp_cls,
                       input int exp_node, input int exp_lvl);
    int lat;
    lat = lat0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " class"}, 32'(out_class), 32'(exp_cls));
    check({tag, " node"}, 32'(out_node), 32'(exp_node));
    check({tag, " level"}, 32'(out_level), 32'(exp_lvl));
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid after handshake", 32'(out_valid), 32'd0);
    check("in_ready after handshake", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst         = 1'b1;
    cfg_we      = 1'b0;
    cfg_addr    = '0;
    cfg_fidx    = '0;
    cfg_thr     = '0;
    cfg_leaf    = 1'b0;
    cfg_class   = '0;
    in_valid    = 1'b0;
    in_features = '0;
    out_ready   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset cfg_busy", 32'(cfg_busy), 32'd0);
    check("reset out_class", 32'(out_class), 32'd0);
    check("reset out_node", 32'(out_node), 32'd0);
    check("reset out_level", 32'(out_level), 32'd0);

    // Left-left walk to leaf node 3.
    program_basic();
    start(feats(5, 3, 0));
    await("leaf3", 0, 3, 2, 3, 2);
    release_result();

    // Right at root, then zero thresholds keep going right to node 14.
    start(feats(15, 0, 0));
    await("right path", 0, 4, 0, 14, 3);
    release_result();

    start(feats(5, 25, 0));
    await("left-right path", 0, 4, 0, 10, 3);
    release_result();

    // Writes and input changes during a walk must not disturb it.
    start(feats(5, 3, 0));
    cfg_we      = 1'b1;
    cfg_addr    = '0;
    cfg_leaf    = 1'b1;
    cfg_class   = 2'd3;
    in_features = feats(200, 200, 0);
    @(negedge clk);
    cfg_we = 1'b0;
    await("walk isolation", 1, 3, 2, 3, 2);
    release_result();
    start(feats(5, 3, 0));
    await("dropped write readback", 0, 3, 2, 3, 2);
    release_result();

    // Table write in the accepting cycle is seen by the walk.
    @(negedge clk);
    in_valid    = 1'b1;
    in_features = feats(5, 3, 0);
    cfg_we      = 1'b1;
    cfg_addr    = '0;
    cfg_fidx    = '0;
    cfg_thr     = '0;
    cfg_leaf    = 1'b1;
    cfg_class   = 2'd1;
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    await("same-cycle write", 0, 1, 1, 0, 0);
    release_result();

    // Root leaf, result held under backpressure.
    start(feats(42, 42, 42));
    await("root leaf", 0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold out_class", 32'(out_class), 32'd1);
      check("hold out_node", 32'(out_node), 32'd0);
      check("hold in_ready", 32'(in_ready), 32'd0);
    end
    release_result();

    // All-zero table: always right, terminates at the depth limit.
    clear_table();
    start(feats(9, 9, 9));
    await("always right", 0, 4, 0, 14, 3);
    release_result();

    // Strict less-than at the threshold boundary.
    cfg(0, 2, 7, 0, 0);
    start(feats(0, 0, 7));
    await("equal goes right", 0, 4, 0, 14, 3);
    release_result();
    start(feats(0, 0, 6));
    await("below goes left", 0, 4, 0, 10, 3);
    release_result();

    // Feature index past the end reads as zero.
    cfg(0, 31, 1, 0, 0);
    start(feats(255, 255, 255));
    await("oob fidx", 0, 4, 0, 10, 3);
    release_result();

    // Reset at level 1 aborts the walk and clears the table.
    program_basic();
    start(feats(5, 3, 0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort cfg_busy", 32'(cfg_busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no result after abort", 32'(out_valid), 32'd0);
    end
    start(feats(5, 3, 0));
    await("cleared table", 0, 4, 0, 14, 3);
    release_result();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
